instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/hack_fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/instr_fetch.sv | 113 +++++++++++
 tb/tb_instr_fetch.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package hack_fetch_pkg;

   localparam int AW_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two deep FIFO with flush and occupancy count.
module fetch_fifo #(
   parameter  int DEPTH = 2,
   parameter  int W     = 32,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          i_rst_b,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   input  logic          i_flush,
   output logic [W-1:0]  o_data,
   output logic          o_valid,
   output logic [CW-1:0] o_count
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_pop;

   assign w_do_pop = i_pop && (r_count != '0);

   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
   always_ff @(posedge clk) begin
      if (!i_rst_b || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({i_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_valid = (r_count != '0);
   assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues one ROM read at a time, buffers {pc, instr} pairs
// for the CPU and handles jump redirects by flushing and dropping in-flight data.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no read outstanding; start one when the buffer has room
// ST_REQ     | read outstanding; data is pushed and the PC advanced on ack
// ST_DISCARD | read outstanding but made stale by a redirect; drop on ack
module instr_fetch
   import hack_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = AW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] pc_value,
   output logic          pc_load,
   output logic          pc_incr,
   output logic [AW-1:0] pc_data,
   output logic          rom_req,
   output logic [AW-1:0] rom_addr,
   input  logic          rom_ack,
   input  logic [AW-1:0] rom_data,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_addr,
   output logic          instr_valid,
   output logic [AW-1:0] instr,
   output logic [AW-1:0] instr_pc,
   input  logic          instr_ready
);

   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_e    r_state;
   logic            r_rom_req;
   logic [AW-1:0]   r_rom_addr;

   logic            w_redirect;
   logic            w_push;
   logic            w_pop;
   logic            w_space;
   logic            w_valid;
   logic [CW-1:0]   w_count;
   logic [2*AW-1:0] w_head;

   assign w_redirect = reset && redirect;
   assign w_push     = reset && (r_state == ST_REQ) && rom_ack && !redirect;
   assign w_pop      = w_valid && instr_ready;
   assign w_space    = (w_count < CW'(DEPTH));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_rom_req  <= 1'b0;
         r_rom_addr <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!redirect && w_space) begin
                  r_state    <= ST_REQ;
                  r_rom_req  <= 1'b1;
                  r_rom_addr <= pc_value;
               end
            end
            ST_REQ: begin
               if (rom_ack) begin
                  r_state   <= ST_IDLE;
                  r_rom_req <= 1'b0;
               end else if (redirect) begin
                  r_state <= ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (rom_ack) begin
                  r_state   <= ST_IDLE;
                  r_rom_req <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_rom_req <= 1'b0;
            end
         endcase
      end
   end

   // A redirect flushes the buffer; the flush also swallows any same-cycle pop.
   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (2 * AW)
   ) u_fifo (
      .clk     (clk),
      .i_rst_b (reset),
      .i_push  (w_push),
      .i_data  ({r_rom_addr, rom_data}),
      .i_pop   (w_pop),
      .i_flush (w_redirect),
      .o_data  (w_head),
      .o_valid (w_valid),
      .o_count (w_count)
   );

   assign pc_load     = w_redirect;
   assign pc_incr     = w_push;
   assign pc_data     = w_redirect ? redirect_addr : '0;
   assign rom_req     = r_rom_req;
   assign rom_addr    = r_rom_addr;
   assign instr_valid = w_valid;
   assign instr       = w_valid ? w_head[AW-1:0] : '0;
   assign instr_pc    = w_valid ? w_head[2*AW-1:AW] : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run
// checked against a sequential-PC reference model.
module tb_instr_fetch;

   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] pc_value;
   logic          pc_load;
   logic          pc_incr;
   logic [AW-1:0] pc_data;
   logic          rom_req;
   logic [AW-1:0] rom_addr;
   logic          rom_ack;
   logic [AW-1:0] rom_data;
   logic          redirect;
   logic [AW-1:0] redirect_addr;
   logic          instr_valid;
   logic [AW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          instr_ready;

   int            n_chk = 0;
   int            n_err = 0;
   int            n_ack = 0;
   int            n_incr = 0;
   bit            rsp_rand = 1'b0;
   int            rsp_dly = 1;
   logic [AW-1:0] exp_pc = '0;
   logic [AW-1:0] e_ins;
   logic [AW-1:0] got_pc [$];
   logic [AW-1:0] got_ins [$];
   logic          prev_rst = 1'b0;
   logic          prev_req = 1'b0;
   logic          prev_ack = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   int            rsp_wt = 0;
   bit            rsp_busy = 1'b0;

   always #5 clk = ~clk;

   instr_fetch #(
      .DEPTH (2),
      .AW    (AW)
   ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .pc_value      (pc_value),
      .pc_load       (pc_load),
      .pc_incr       (pc_incr),
      .pc_data       (pc_data),
      .rom_req       (rom_req),
      .rom_addr      (rom_addr),
      .rom_ack       (rom_ack),
      .rom_data      (rom_data),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_ready   (instr_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      redirect = 1'b0;
      repeat (2) cyc();
      reset = 1'b1;
   endtask

   // Program counter the fetch unit steers.
   always @(posedge clk) begin
      if (!reset)       pc_value <= '0;
      else if (pc_load) pc_value <= pc_data;
      else if (pc_incr) pc_value <= pc_value + 16'd1;
   end

   // ROM: acks rsp_dly cycles after the request is first seen, data 0xE000+addr.
   initial begin
      rom_ack  = 1'b0;
      rom_data = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rom_req) begin
            rsp_busy = 1'b0;
            rom_ack  = 1'b0;
            rom_data = '0;
         end else begin
            if (!rsp_busy) begin
               rsp_busy = 1'b1;
               rsp_wt   = rsp_rand ? int'($urandom_range(0, 5)) : rsp_dly;
            end
            if (rsp_wt == 0) begin
               rom_ack  = 1'b1;
               rom_data = 16'hE000 + rom_addr;
               rsp_busy = 1'b0;
            end else begin
               rsp_wt--;
               rom_ack  = 1'b0;
               rom_data = '0;
            end
         end
      end
   end

   // Reference model: consumed instructions run sequentially from the last jump target.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            exp_pc = '0;
         end else begin
            chk("ld_incr_excl", {31'd0, pc_load & pc_incr}, 32'd0);
            if (!pc_load) chk("pc_data_idle", pc_data, 32'd0);
            if (rom_ack) n_ack++;
            if (pc_incr) n_incr++;
            if (prev_rst && prev_req && !prev_ack) begin
               chk("req_hold", rom_req, 32'd1);
               chk("addr_hold", rom_addr, prev_addr);
            end
            if (redirect) begin
               exp_pc = redirect_addr;
            end else if (instr_valid && instr_ready) begin
               e_ins = 16'hE000 + exp_pc;
               chk("sb_pc", instr_pc, exp_pc);
               chk("sb_ins", instr, e_ins);
               got_pc.push_back(instr_pc);
               got_ins.push_back(instr);
               exp_pc = exp_pc + 16'd1;
            end
         end
         prev_rst  = reset;
         prev_req  = rom_req;
         prev_ack  = rom_ack;
         prev_addr = rom_addr;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b0;
      instr_ready   = 1'b0;
      redirect      = 1'b0;
      redirect_addr = '0;

      // reset values
      repeat (3) cyc();
      chk("rst_req", rom_req, 0);
      chk("rst_addr", rom_addr, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_load", pc_load, 0);
      chk("rst_incr", pc_incr, 0);
      chk("rst_pcdata", pc_data, 0);
      chk("rst_instr", instr, 0);
      chk("rst_ipc", instr_pc, 0);

      // streaming with 1-cycle ROM, CPU always ready
      instr_ready = 1'b1;
      rsp_dly     = 1;
      reset       = 1'b1;
      n_ack = 0; n_incr = 0;
      got_pc.delete(); got_ins.delete();
      for (int i = 0; i < 20 && !rom_ack; i++) cyc();
      chk("t1_ack_seen", rom_ack, 1);
      chk("t1_incr_on_ack", pc_incr, 1);
      chk("t1_empty_before", instr_valid, 0);
      cyc();
      chk("t1_lat_valid", instr_valid, 1);
      chk("t1_lat_pc", instr_pc, 0);
      chk("t1_lat_ins", instr, 32'hE000);
      for (int i = 0; i < 40 && got_pc.size() < 3; i++) cyc();
      if (got_pc.size() >= 3) begin
         for (int k = 0; k < 3; k++) begin
            chk("t1_stream_pc", got_pc[k], k);
            chk("t1_stream_ins", got_ins[k], 32'hE000 + k);
         end
      end else begin
         chk("t1_stream_len", got_pc.size(), 3);
      end
      chk("t1_incr_per_ack", n_incr, n_ack);

      // CPU stalled: buffer fills to DEPTH and requests stop
      instr_ready = 1'b0;
      rsp_dly     = 1;
      do_reset();
      n_ack = 0;
      repeat (10) cyc();
      chk("t2_req_off", rom_req, 0);
      chk("t2_acks", n_ack, 2);
      chk("t2_valid", instr_valid, 1);
      chk("t2_hold_ins", instr, 32'hE000);
      chk("t2_hold_pc", instr_pc, 0);
      got_pc.delete(); got_ins.delete();
      instr_ready = 1'b1;
      for (int i = 0; i < 40 && got_pc.size() < 3; i++) cyc();
      if (got_pc.size() >= 3) begin
         for (int k = 0; k < 3; k++) chk("t2_drain_pc", got_pc[k], k);
      end else begin
         chk("t2_drain_len", got_pc.size(), 3);
      end

      // redirect in IDLE to 0x0005, then redirect to 0x0100 while 0x0005 pending
      instr_ready = 1'b0;
      rsp_dly     = 3;
      do_reset();
      got_pc.delete(); got_ins.delete();
      redirect      = 1'b1;
      redirect_addr = 16'h0005;
      #1;
      chk("t3_load_idle", pc_load, 1);
      chk("t3_data_idle", pc_data, 32'h0005);
      cyc();
      redirect = 1'b0;
      chk("t3_no_req", rom_req, 0);
      cyc();
      chk("t3_req", rom_req, 1);
      chk("t3_addr", rom_addr, 32'h0005);
      redirect      = 1'b1;
      redirect_addr = 16'h0100;
      #1;
      chk("t3_load", pc_load, 1);
      chk("t3_pcdata", pc_data, 32'h0100);
      chk("t3_noincr", pc_incr, 0);
      cyc();
      redirect = 1'b0;
      chk("t3_disc_req", rom_req, 1);
      chk("t3_disc_addr", rom_addr, 32'h0005);
      chk("t3_disc_valid", instr_valid, 0);
      for (int i = 0; i < 10 && !rom_ack; i++) cyc();
      chk("t3_ack_seen", rom_ack, 1);
      chk("t3_ack_noincr", pc_incr, 0);
      instr_ready = 1'b1;
      for (int i = 0; i < 20 && got_pc.size() < 1; i++) cyc();
      if (got_pc.size() >= 1) begin
         chk("t3_next_pc", got_pc[0], 32'h0100);
         chk("t3_next_ins", got_ins[0], 32'hE100);
      end else begin
         chk("t3_next_len", got_pc.size(), 1);
      end

      // redirect to 0x00A1 coincident with ack
      instr_ready = 1'b0;
      rsp_dly     = 1;
      do_reset();
      n_incr = 0;
      cyc();
      cyc();
      chk("t4_ack", rom_ack, 1);
      redirect      = 1'b1;
      redirect_addr = 16'h00A1;
      #1;
      chk("t4_load", pc_load, 1);
      chk("t4_pcdata", pc_data, 32'h00A1);
      chk("t4_noincr", pc_incr, 0);
      cyc();
      redirect = 1'b0;
      chk("t4_valid", instr_valid, 0);
      chk("t4_idle", rom_req, 0);
      cyc();
      chk("t4_req", rom_req, 1);
      chk("t4_addr", rom_addr, 32'h00A1);
      chk("t4_incr_cnt", n_incr, 0);

      // reset while a request is outstanding
      instr_ready = 1'b0;
      rsp_dly     = 1;
      do_reset();
      repeat (4) cyc();
      chk("t5_pre_req", rom_req, 1);
      chk("t5_pre_addr", rom_addr, 1);
      chk("t5_pre_valid", instr_valid, 1);
      reset = 1'b0;
      cyc();
      chk("t5_req", rom_req, 0);
      chk("t5_addr", rom_addr, 0);
      chk("t5_valid", instr_valid, 0);
      chk("t5_instr", instr, 0);
      chk("t5_ipc", instr_pc, 0);
      chk("t5_load", pc_load, 0);
      chk("t5_incr", pc_incr, 0);
      chk("t5_pcdata", pc_data, 0);

      // random ack delay, random ready, random redirects
      rsp_rand = 1'b1;
      do_reset();
      got_pc.delete(); got_ins.delete();
      for (int i = 0; i < 2000; i++) begin
         cyc();
         instr_ready   = 1'($urandom_range(0, 1));
         redirect      = ($urandom_range(0, 15) == 0);
         redirect_addr = 16'($urandom);
      end
      cyc();
      redirect    = 1'b0;
      instr_ready = 1'b0;
      chk("t6_consumed", got_pc.size() > 100, 1);
      cyc();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
